// File: rtl/rename_pkg.sv
// rename_pkg: shared rename-stage widths and types used by the free list, RAT and ROB.
package rename_pkg;
  localparam int NUM_ARCH_REGS = 35;
  localparam int NUM_PHYS_REGS = 64;
  localparam int LOG_PHYS = $clog2(NUM_PHYS_REGS);
  localparam int LOG_ARCH = $clog2(NUM_ARCH_REGS);
  localparam int FL_DEPTH = NUM_PHYS_REGS - 1;
  localparam int ARCH_LO = 33;
  localparam int ARCH_HI = 34;
  typedef logic [LOG_PHYS-1:0] phys_reg_t;
endpackage

// File: rtl/fl_ptr_inc.sv
// fl_ptr_inc: modulo-FL_DEPTH pointer increment; the depth is not a power of two.
module fl_ptr_inc
  import rename_pkg::*;
(
  input  logic [LOG_PHYS-1:0] ptr,
  output logic [LOG_PHYS-1:0] nxt
);
  assign nxt = (ptr == LOG_PHYS'(FL_DEPTH - 1)) ? '0 : ptr + 1'b1;
endmodule

// File: rtl/free_list.sv
// free_list: physical-register free list with speculative and committed head pointers.
module free_list
  import rename_pkg::*;
(
  input  logic                CLK,
  input  logic                RESET,
  input  logic                alloc_req,
  output phys_reg_t           alloc_reg,
  output logic                alloc_valid,
  input  logic                free_valid,
  input  phys_reg_t           free_reg,
  input  logic                commit_alloc,
  input  logic                flush,
  output logic [LOG_PHYS-1:0] free_count,
  output logic                overflow
);
  localparam logic [LOG_PHYS-1:0] FULL = LOG_PHYS'(FL_DEPTH);
  phys_reg_t mem [FL_DEPTH];
  logic [LOG_PHYS-1:0] head, cmt_head, tail, head_inc, cmt_head_inc, tail_inc;
  logic [LOG_PHYS-1:0] count, cmt_count, cmt_count_nxt;
  logic do_alloc, do_free, free_full;
  fl_ptr_inc u_head (.ptr(head), .nxt(head_inc));
  fl_ptr_inc u_cmt_head (.ptr(cmt_head), .nxt(cmt_head_inc));
  fl_ptr_inc u_tail (.ptr(tail), .nxt(tail_inc));
  assign alloc_reg = mem[head];
  assign alloc_valid = count != '0;
  assign free_count = count;
  always_comb begin
    do_alloc = alloc_req && alloc_valid && !flush;
    do_free = free_valid && free_reg != '0 && count != FULL;
    free_full = free_valid && free_reg != '0 && count == FULL;
    cmt_count_nxt = cmt_count + LOG_PHYS'(do_free) - LOG_PHYS'(commit_alloc);
  end
  // Flush rebuilds the speculative view from the committed one, including same-cycle commit/free.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FL_DEPTH; i++) mem[i] <= phys_reg_t'(i + 1);
      head <= '0;
      cmt_head <= '0;
      tail <= '0;
      count <= FULL;
      cmt_count <= FULL;
      overflow <= 1'b0;
    end else begin
      if (do_free) begin
        mem[tail] <= free_reg;
        tail <= tail_inc;
      end
      if (free_full) overflow <= 1'b1;
      if (commit_alloc) cmt_head <= cmt_head_inc;
      cmt_count <= cmt_count_nxt;
      head <= flush ? (commit_alloc ? cmt_head_inc : cmt_head) : do_alloc ? head_inc : head;
      count <= flush ? cmt_count_nxt : count + LOG_PHYS'(do_free) - LOG_PHYS'(do_alloc);
    end
  end
endmodule
